// File: rtl/frame_sync_buffer.sv
// frame_sync_buffer: tear-free double-buffered channel bank.
// The producer fills a shadow bank, then commits it. The commit handshake is
// skipped in free-run mode. At the first cycle of vertical blanking, the
// shadow set is copied into the active bank in one edge. The pixel generator
// only ever sees the active bank.
module frame_sync_buffer #(
    parameter int               NUM_CH    = 10,
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8,
    localparam int              IDX_W     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_ready,
    input  logic                    commit,
    input  logic                    vs_n,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NUM_CH*WIDTH-1:0] active_flat,
    output logic                    pending,
    output logic                    swap_pulse,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        overrun_cnt
);

    // NUM_CH widened by one bit so index range checks never truncate
    localparam logic [IDX_W:0] NUM_CH_L = (IDX_W+1)'(NUM_CH);

    logic [WIDTH-1:0] shadow [NUM_CH];
    logic [WIDTH-1:0] active [NUM_CH];
    logic             vs_n_d;
    logic             vblank_start;
    logic             do_copy;
    logic             wr_ok;
    logic             overrun;

    assign vblank_start = vs_n_d & ~vs_n;
    assign wr_ready     = mode | ~pending;
    assign wr_ok        = wr_en & wr_ready & ({1'b0, wr_idx} < NUM_CH_L);
    // Free-run copies every frame; commit mode only copies a committed set.
    assign do_copy      = vblank_start & (mode | pending);
    // A commit coincident with the copy refills pending and is not a loss.
    assign overrun      = ~mode & commit & pending & ~vblank_start;

    // Bank storage: the copy reads pre-edge shadow, so a same-edge write
    // lands in shadow only and shows up on the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RESET_VAL;
                active[i] <= RESET_VAL;
            end
        end else begin
            if (do_copy) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_ok) begin
                shadow[wr_idx] <= wr_data;
            end
        end
    end

    // Handshake state, sync edge detector and frame/overrun bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_n_d      <= 1'b1;
            pending     <= 1'b0;
            swap_pulse  <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            vs_n_d     <= vs_n;
            swap_pulse <= do_copy;

            if (mode) begin
                if (vblank_start) begin
                    pending <= 1'b0;
                end
            end else if (do_copy) begin
                pending <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (do_copy) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (overrun && !(&overrun_cnt)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

    // Per-channel read port; out-of-range indices read as zero
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < NUM_CH_L) begin
            rd_data = active[rd_idx];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign active_flat[g*WIDTH +: WIDTH] = active[g];
    end

endmodule

// File: doc/frame_sync_buffer.md
Name: frame_sync_buffer

Overview:
- Parametrised, tear-free snapshot buffer between the game-logic producer and the VGA pixel generator.
- The producer fills a shadow bank of NUM_CH channels, WIDTH bits each, then commits the complete set.
- At the start of vertical blanking the committed set is copied into the active bank in one cycle. The pixel generator reads only the active bank.
- Generalises the single-purpose vblank latch to any channel count and width. Adds a commit handshake, a free-running mode, frame and overrun counters, and a per-channel read port.

Parameters:
- NUM_CH, 10, number of channels (entries) per bank; must be at least 2.
- WIDTH, 10, bits per channel.
- RESET_VAL, 0, value loaded into every shadow and active entry on reset (WIDTH bits).
- CNT_W, 8, width of frame_cnt and overrun_cnt.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- mode  in  1  0 = commit mode (swap only a committed set); 1 = free-run mode (swap shadow every vblank).
- wr_en  in  1  shadow write strobe.
- wr_idx  in  IDX_W=$clog2(NUM_CH)  shadow entry index.
- wr_data  in  WIDTH  shadow write data.
- wr_ready  out  1  shadow accepts writes.
- commit  in  1  single-cycle pulse: shadow set is complete.
- vs_n  in  1  VGA vertical sync, active-low, synchronous to clk.
- rd_idx  in  IDX_W  active-bank read index.
- rd_data  out  WIDTH  active[rd_idx], combinational.
- active_flat  out  NUM_CH*WIDTH  whole active bank; entry i occupies bits [i*WIDTH +: WIDTH].
- pending  out  1  a committed set is waiting for vblank.
- swap_pulse  out  1  high for one cycle after each copy.
- frame_cnt  out  CNT_W  number of copies performed, wraps.
- overrun_cnt  out  CNT_W  commits lost, saturating.

Behaviour:
- Reset (rst=1 at a clk edge): all shadow and active entries = RESET_VAL. pending=0, swap_pulse=0, frame_cnt=0, overrun_cnt=0, vs_n_d=1. rst overrides every other input in the same cycle.
- vblank_start = vs_n_d & ~vs_n, where vs_n_d is vs_n registered. The copy happens at the first edge where vblank_start=1.
  - Copy latency: the new active bank is visible in the cycle after that edge.
  - swap_pulse is high in that same cycle.
  - Exactly one copy per VS falling edge, even if VS stays low.
- wr_ready = mode | ~pending.
- A write with wr_en & wr_ready & (wr_idx < NUM_CH) updates shadow[wr_idx] at the edge.
  - A write with wr_ready=0 is dropped silently and shadow is unchanged.
  - A write with wr_idx >= NUM_CH is dropped silently and shadow is unchanged.
- Commit mode (mode=0):
  - commit with pending=0 sets pending=1.
  - commit with pending=1 leaves pending=1 and increments overrun_cnt (saturates at all-ones).
  - At vblank_start with pending=1: active <= shadow, pending <= 0, frame_cnt++.
  - At vblank_start with pending=0: no copy, no swap_pulse, frame_cnt unchanged.
- Free-run mode (mode=1):
  - Every vblank_start copies shadow to active and increments frame_cnt. pending is cleared.
  - commit has no effect and never counts as an overrun.
- Same-edge events:
  - Write and vblank_start on the same edge: the copy uses the pre-write shadow value; the write lands in shadow. In mode 0 the write is only possible when pending=0, and then no copy occurs.
  - commit and vblank_start on the same edge, with pending=1: the copy consumes the old pending set, pending is set again, and no overrun is counted.
  - commit and vblank_start on the same edge, with pending=0 (mode 0): pending=1 and no copy this frame.
- Mode change: takes effect at the next edge. Switching 1→0 with pending=0 keeps the active bank unchanged until the next commit.
- Reset mid-operation: the shadow contents and any pending set are discarded; the active bank returns to RESET_VAL immediately.
- frame_cnt wraps modulo 2^CNT_W.
- rd_data: for rd_idx >= NUM_CH, rd_data = 0.

Test Plan:
- Reset check, NUM_CH=10, WIDTH=10, RESET_VAL=700 → all of active_flat reads 700, pending=0, wr_ready=1, both counters 0.
- Commit mode, normal frame: write ch3=123 and ch9=45, pulse commit, then drop vs_n → before the edge active[3]=700. One cycle after vblank_start: active[3]=123, active[9]=45, swap_pulse=1 for exactly one cycle, frame_cnt=1, pending=0.
- Commit mode, locked shadow: commit, then write ch0=5 while pending=1 → wr_ready=0, ch0 unchanged after the swap. A second commit before vblank gives overrun_cnt=1. Repeat 300 overruns with CNT_W=8 → overrun_cnt=255.
- Commit mode, idle frames: 3 VS falling edges with no commit → no swap_pulse, frame_cnt unchanged, active unchanged.
- Free-run mode: mode=1, write ch1=7 on the vblank_start edge → that frame's copy leaves active[1] at its old value; the next frame's copy gives active[1]=7. frame_cnt increments on every VS falling edge; commit pulses leave overrun_cnt at 0.
- Same-edge and reset cases:
  - commit coincident with vblank_start while pending=1 → one copy, pending=1 afterward, overrun_cnt unchanged.
  - rst asserted mid-pending → active=RESET_VAL next cycle, pending=0.
